// File: rtl/fu_branch_if.sv
// Issue/result bundle for the branch functional unit.
// Signal names match the unit's port list so each side reads naturally.
interface fu_branch_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             enable;
  logic             ready;
  logic [2:0]       br_type;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             flush;
  logic             resolved;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  link_addr;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output enable, br_type, rs1, rs2, pc, imm, pred_taken, pred_target, flush,
    input  ready, resolved, taken, mispredict, target, link_addr, mispredict_count
  );

  modport slave (
    input  enable, br_type, rs1, rs2, pc, imm, pred_taken, pred_target, flush,
    output ready, resolved, taken, mispredict, target, link_addr, mispredict_count
  );
endinterface

// File: rtl/fu_branch.sv
// Two-stage branch resolution unit: S1 compares and forms the target, S2 checks
// the fetch prediction, redirects on mispredict and keeps a saturating tally.
module fu_branch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          nrst,
  fu_branch_if.slave    bus
);

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd7;

  logic             cond;
  logic             is_jump;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  taken_target;
  logic [XLEN-1:0]  s1_target_d;

  logic             accept;
  logic             kill_s1;
  logic             ready_int;
  logic             mis_d;

  logic             ready_en_q;
  logic             bubble_q;

  logic             s1_valid;
  logic             s1_taken;
  logic [XLEN-1:0]  s1_target;
  logic [XLEN-1:0]  s1_link;
  logic             s1_pred_taken;
  logic [XLEN-1:0]  s1_pred_target;

  logic             res_q;
  logic             taken_q;
  logic             mis_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  link_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cond = 1'b1;
    case (bus.br_type)
      BR_BEQ:  cond = (bus.rs1 == bus.rs2);
      BR_BNE:  cond = (bus.rs1 != bus.rs2);
      BR_BLT:  cond = ($signed(bus.rs1) < $signed(bus.rs2));
      BR_BGE:  cond = !($signed(bus.rs1) < $signed(bus.rs2));
      BR_BLTU: cond = (bus.rs1 < bus.rs2);
      BR_BGEU: cond = !(bus.rs1 < bus.rs2);
      default: cond = 1'b1;
    endcase
  end

  assign is_jump      = bus.br_type[2] & bus.br_type[1];
  assign pc_plus4     = bus.pc + XLEN'(4);
  assign jalr_sum     = bus.rs1 + bus.imm;
  assign taken_target = (bus.br_type == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                 : bus.pc + bus.imm;
  // Not-taken still reports the fall-through PC so target is always the next PC.
  assign s1_target_d  = cond ? taken_target : pc_plus4;

  // A resolving mispredict kills the younger op in S1 and opens a 2-cycle bubble.
  assign kill_s1   = res_q & mis_q;
  assign ready_int = ready_en_q & ~kill_s1 & ~bubble_q;
  assign accept    = bus.enable & ready_int & ~bus.flush;

  assign mis_d = (s1_taken != s1_pred_taken) ||
                 (s1_taken && (s1_pred_target != s1_target));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_en_q     <= 1'b0;
      bubble_q       <= 1'b0;
      s1_valid       <= 1'b0;
      s1_taken       <= 1'b0;
      s1_target      <= '0;
      s1_link        <= '0;
      s1_pred_taken  <= 1'b0;
      s1_pred_target <= '0;
      res_q          <= 1'b0;
      taken_q        <= 1'b0;
      mis_q          <= 1'b0;
      target_q       <= '0;
      link_q         <= '0;
      cnt_q          <= '0;
    end else begin
      ready_en_q <= 1'b1;
      bubble_q   <= kill_s1;
      s1_valid   <= accept;
      if (accept) begin
        s1_taken       <= cond;
        s1_target      <= s1_target_d;
        s1_link        <= is_jump ? pc_plus4 : '0;
        s1_pred_taken  <= bus.pred_taken;
        s1_pred_target <= bus.pred_target;
      end
      if (s1_valid && !kill_s1 && !bus.flush) begin
        res_q    <= 1'b1;
        taken_q  <= s1_taken;
        mis_q    <= mis_d;
        target_q <= s1_target;
        link_q   <= s1_link;
        if (mis_d && (cnt_q != {CNT_W{1'b1}}))
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        res_q    <= 1'b0;
        taken_q  <= 1'b0;
        mis_q    <= 1'b0;
        target_q <= '0;
        link_q   <= '0;
      end
    end
  end

  assign bus.ready            = ready_int;
  assign bus.resolved         = res_q;
  assign bus.taken            = taken_q;
  assign bus.mispredict       = mis_q;
  assign bus.target           = target_q;
  assign bus.link_addr        = link_q;
  assign bus.mispredict_count = cnt_q;

endmodule

// File: tb/tb_fu_branch.sv
// Directed bench for fu_branch: hand-computed vectors checked with immediate assertions.
module tb_fu_branch;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic nrst;
  int   errors;
  int   checks;
  int   mis_seen;

  fu_branch_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  fu_branch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic pt, input logic [31:0] ptg);
    bus.enable      = 1'b1;
    bus.br_type     = t;
    bus.rs1         = a;
    bus.rs2         = b;
    bus.pc          = p;
    bus.imm         = i;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
  endtask

  task automatic check_res(input string tag, input logic tk, input logic mp,
                           input logic [31:0] tg, input logic [31:0] lk);
    check({tag, ".resolved"},   64'(bus.resolved),   64'd1);
    check({tag, ".taken"},      64'(bus.taken),      64'(tk));
    check({tag, ".mispredict"}, 64'(bus.mispredict), 64'(mp));
    check({tag, ".target"},     64'(bus.target),     64'(tg));
    check({tag, ".link"},       64'(bus.link_addr),  64'(lk));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".resolved"}, 64'(bus.resolved),   64'd0);
    check({tag, ".target"},   64'(bus.target),     64'd0);
    check({tag, ".taken"},    64'(bus.taken),      64'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    mis_seen = 0;
    nrst     = 1'b0;
    bus.flush = 1'b0;
    set_op(3'd0, 0, 0, 0, 0, 1'b0, 0);
    bus.enable = 1'b0;

    // Reset state
    #2;
    check("rst.resolved", 64'(bus.resolved), 64'd0);
    check("rst.count",    64'(bus.mispredict_count), 64'd0);
    check("rst.target",   64'(bus.target), 64'd0);
    tick();
    tick();
    #1 nrst = 1'b1;
    tick();
    check("rst.ready_after_release", 64'(bus.ready), 64'd1);

    // BEQ correctly predicted taken
    set_op(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120);
    tick();
    bus.enable = 1'b0;
    check("beq.lat1", 64'(bus.resolved), 64'd0);
    tick();
    check_res("beq", 1'b1, 1'b0, 32'h120, 32'h0);
    check("beq.ready", 64'(bus.ready), 64'd1);
    tick();
    check_idle("beq.after");

    // BLT signed: -1 < 1 taken, predicted not-taken -> mispredict
    set_op(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0, 32'h0);
    tick();
    bus.enable = 1'b0;
    tick();
    check_res("blt", 1'b1, 1'b1, 32'h210, 32'h0);
    check("blt.count", 64'(bus.mispredict_count), 64'd1);
    check("blt.ready_resolve", 64'(bus.ready), 64'd0);
    tick();
    check("blt.ready_bubble", 64'(bus.ready), 64'd0);
    check_idle("blt.after");
    tick();
    check("blt.ready_back", 64'(bus.ready), 64'd1);

    // BLTU same operands: not taken, target falls through
    set_op(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b0, 32'h0);
    tick();
    bus.enable = 1'b0;
    tick();
    check_res("bltu", 1'b0, 1'b0, 32'h304, 32'h0);
    check("bltu.count", 64'(bus.mispredict_count), 64'd1);

    // JALR clears bit 0 of rs1+imm, links pc+4
    set_op(3'd7, 32'h203, 32'h0, 32'h40, 32'h0, 1'b1, 32'h202);
    tick();
    bus.enable = 1'b0;
    tick();
    check_res("jalr", 1'b1, 1'b0, 32'h202, 32'h44);

    // Mispredict kills the younger op; 2-cycle bubble; third op accepted after
    set_op(3'd1, 32'd1, 32'd1, 32'h80, 32'h8, 1'b1, 32'h500);
    tick();
    check("kill.ready_b", 64'(bus.ready), 64'd1);
    set_op(3'd6, 32'd0, 32'd0, 32'h90, 32'h10, 1'b1, 32'hA0);
    tick();
    bus.enable = 1'b0;
    check_res("kill.a", 1'b0, 1'b1, 32'h84, 32'h0);
    check("kill.count", 64'(bus.mispredict_count), 64'd2);
    check("kill.ready0", 64'(bus.ready), 64'd0);
    tick();
    check("kill.b_never", 64'(bus.resolved), 64'd0);
    check("kill.ready1", 64'(bus.ready), 64'd0);
    set_op(3'd3, 32'd5, 32'd3, 32'h600, 32'h40, 1'b1, 32'h640);
    tick();
    check("kill.ready2", 64'(bus.ready), 64'd1);
    check("kill.b_never2", 64'(bus.resolved), 64'd0);
    tick();
    bus.enable = 1'b0;
    check("kill.c_not_early", 64'(bus.resolved), 64'd0);
    tick();
    check_res("kill.c", 1'b1, 1'b0, 32'h640, 32'h0);

    // Flush: a resolving result still outputs, younger op and same-cycle enable dropped
    tick();
    set_op(3'd0, 32'd7, 32'd7, 32'h800, 32'h4, 1'b1, 32'h804);
    tick();
    set_op(3'd0, 32'd7, 32'd7, 32'h900, 32'h4, 1'b1, 32'h904);
    tick();
    set_op(3'd0, 32'd7, 32'd7, 32'hA00, 32'h4, 1'b1, 32'hA04);
    bus.flush = 1'b1;
    check_res("flush.p", 1'b1, 1'b0, 32'h804, 32'h0);
    tick();
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    check_idle("flush.q1");
    tick();
    check_idle("flush.q2");
    tick();
    check_idle("flush.q3");

    // Saturation of the mispredict tally
    set_op(3'd0, 32'd0, 32'd1, 32'h1000, 32'h8, 1'b1, 32'h1008);
    for (int n = 0; n < 120; n++) begin
      tick();
      if (bus.resolved && bus.mispredict) mis_seen++;
    end
    bus.enable = 1'b0;
    check("sat.enough_mispredicts", 64'(mis_seen >= 14), 64'd1);
    check("sat.count", 64'(bus.mispredict_count), 64'hF);
    tick();
    tick();
    tick();
    check("sat.hold", 64'(bus.mispredict_count), 64'hF);

    // Async reset with two ops in flight
    tick();
    tick();
    set_op(3'd0, 32'd3, 32'd3, 32'h700, 32'h8, 1'b1, 32'h708);
    tick();
    set_op(3'd0, 32'd3, 32'd3, 32'h710, 32'h8, 1'b1, 32'h718);
    tick();
    bus.enable = 1'b0;
    check("arst.pre_resolved", 64'(bus.resolved), 64'd1);
    #2 nrst = 1'b0;
    #1;
    check("arst.resolved",   64'(bus.resolved),         64'd0);
    check("arst.taken",      64'(bus.taken),            64'd0);
    check("arst.mispredict", 64'(bus.mispredict),       64'd0);
    check("arst.target",     64'(bus.target),           64'd0);
    check("arst.link",       64'(bus.link_addr),        64'd0);
    check("arst.count",      64'(bus.mispredict_count), 64'd0);
    #2 nrst = 1'b1;
    tick();
    check("arst.ready", 64'(bus.ready), 64'd1);
    check_idle("arst.post1");
    tick();
    check_idle("arst.post2");
    tick();
    check_idle("arst.post3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fu_branch.md
FU_BRANCH -- requirements
Module: fu_branch

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC width.
REQ-002 SHALL have parameter CNT_W, default 16, mispredict counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  issue valid; op accepted when enable && ready.
REQ-006 SHALL have port ready  output  1  unit can accept an op this cycle.
REQ-007 SHALL have port br_type  input  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR.
REQ-008 SHALL have ports rs1, rs2, pc, imm  input  XLEN each  operands, branch PC, sign-extended offset.
REQ-009 SHALL have ports pred_taken  input  1 and pred_target  input  XLEN  fetch prediction.
REQ-010 SHALL have port flush  input  1  kill all in-flight ops.
REQ-011 SHALL have port resolved  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have ports taken  output  1, mispredict  output  1, target  output  XLEN, link_addr  output  XLEN.
REQ-013 SHALL have port mispredict_count  output  CNT_W  saturating mispredict tally.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 (compare, target add) registered at accept edge, S2 (prediction check) registered next edge; resolved asserts 2 cycles after the accept edge.
REQ-015 SHALL compute taken: BEQ rs1==rs2, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned, JAL/JALR always 1.
REQ-016 SHALL compute target = pc+imm for conditional/JAL, (rs1+imm) with bit 0 cleared for JALR, modulo 2^XLEN (wrap, no overflow flag).
REQ-017 SHALL drive link_addr = pc+4 for JAL/JALR, 0 otherwise.
REQ-018 SHALL assert mispredict when taken != pred_taken, or taken && pred_target != target.
REQ-019 SHALL drive target = pc+4 on a not-taken branch so target is always the correct next PC.
REQ-020 SHALL accept back-to-back ops at one per cycle while no mispredict is resolving.
REQ-021 SHALL deassert ready in the cycle resolved&&mispredict is high and the following cycle (2-cycle redirect bubble); ops presented then are not accepted.
REQ-022 SHALL, when a mispredict resolves, invalidate the op in S1 (younger, wrong path); it never produces resolved.
REQ-023 SHALL, on flush, clear S1 and S2 valid at the next edge; flush wins over enable in the same cycle (no accept), and a result resolving that cycle still outputs.
REQ-024 SHALL increment mispredict_count by 1 per resolved mispredict, saturating at all-ones (no wrap).
REQ-025 SHALL hold taken, mispredict, target, link_addr at 0 whenever resolved is 0.

Reset
REQ-026 SHALL, on nrst low, immediately clear both stage valids, mispredict_count, resolved, taken, mispredict, target, link_addr to 0, independent of clk.
REQ-027 SHALL drive ready 1 from the first edge after nrst release; reset mid-operation discards in-flight ops with no resolved pulse.

Verification
REQ-028 BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> resolved 2 cycles later, taken=1, mispredict=0, target=0x120.
REQ-029 BLT rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, mispredict=1, count 0->1; BLTU same operands -> taken=0, target=pc+4.
REQ-030 JALR rs1=0x203, imm=0, pc=0x40 -> target=0x202, link_addr=0x44, taken=1.
REQ-031 Mispredicting op followed by a second op next cycle -> second op never resolves; ready low 2 cycles; third op accepted after.
REQ-032 Force count to all-ones via repeated mispredicts (CNT_W=4: 16+ mispredicts) -> holds 0xF.
REQ-033 nrst low while 2 ops in flight -> all outputs 0 without a clock edge; no resolved after release.
